// File: rtl/puzzle_loader.sv
// Streams one randomly chosen sudoku puzzle out of a synchronous ROM into shadow
// registers, then publishes the digit and visibility buses together in a single cycle.
module puzzle_loader #(
  parameter int unsigned NUM_PUZZLES = 8,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              difficulty,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [5:0]        rom_data,
  output logic [323:0]      selected_map,
  output logic [161:0]      selected_visibility,
  output logic [3:0]        puzzle_id,
  output logic              busy,
  output logic              done,
  output logic              load_error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [7:0]        NUM_P8    = 8'(NUM_PUZZLES);
  localparam logic [ADDR_W-1:0] CELLS     = ADDR_W'(81);
  localparam logic [6:0]        LAST_CELL = 7'd80;

  logic [1:0]        state_q, state_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [3:0]        idx_q, idx_d;
  logic              diff_q, diff_d;
  logic [6:0]        cell_q, cell_d;
  logic [6:0]        cap_cell_q, cap_cell_d;
  logic              cap_valid_q, cap_valid_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [323:0]      shadow_map_q, shadow_map_d;
  logic [161:0]      shadow_vis_q, shadow_vis_d;
  logic              bad_q, bad_d;
  logic [323:0]      map_q, map_d;
  logic [161:0]      vis_q, vis_d;
  logic [3:0]        puzzle_id_q, puzzle_id_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_error_q, load_error_d;
  logic [7:0]        idx_mod;
  logic              shown;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    idx_d        = idx_q;
    diff_d       = diff_q;
    cell_d       = cell_q;
    cap_cell_d   = cap_cell_q;
    cap_valid_d  = 1'b0;
    rom_addr_d   = rom_addr_q;
    shadow_map_d = shadow_map_q;
    shadow_vis_d = shadow_vis_q;
    bad_d        = bad_q;
    map_d        = map_q;
    vis_d        = vis_q;
    puzzle_id_d  = puzzle_id_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load_error_d = load_error_q;
    idx_mod      = lfsr_q % NUM_P8;
    shown        = diff_q ? rom_data[5] : rom_data[4];

    // ROM data arrives one cycle after its address; cap_cell_q names the cell it belongs to.
    if (cap_valid_q) begin
      shadow_map_d[{cap_cell_q, 2'b00} +: 4] = rom_data[3:0];
      shadow_vis_d[{cap_cell_q, 1'b0} +: 2]  = shown ? 2'b11 : 2'b00;
      if (rom_data[3:0] == 4'd0 || rom_data[3:0] > 4'd9) begin
        bad_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          idx_d        = idx_mod[3:0];
          diff_d       = difficulty;
          cell_d       = '0;
          rom_addr_d   = ADDR_W'(idx_mod) * CELLS;
          shadow_map_d = '0;
          shadow_vis_d = '0;
          bad_d        = 1'b0;
          load_error_d = 1'b0;
          map_d        = '0;
          vis_d        = '0;
          busy_d       = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        cap_valid_d = 1'b1;
        cap_cell_d  = cell_q;
        if (cell_q == LAST_CELL) begin
          state_d = S_DRAIN;
        end else begin
          cell_d     = cell_q + 7'd1;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_COMMIT;
      end
      default: begin
        if (!bad_q) begin
          map_d       = shadow_map_q;
          vis_d       = shadow_vis_q;
          puzzle_id_d = idx_q;
          done_d      = 1'b1;
        end else begin
          load_error_d = 1'b1;
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= 8'h01;
      idx_q        <= '0;
      diff_q       <= 1'b0;
      cell_q       <= '0;
      cap_cell_q   <= '0;
      cap_valid_q  <= 1'b0;
      rom_addr_q   <= '0;
      shadow_map_q <= '0;
      shadow_vis_q <= '0;
      bad_q        <= 1'b0;
      map_q        <= '0;
      vis_q        <= '0;
      puzzle_id_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      idx_q        <= idx_d;
      diff_q       <= diff_d;
      cell_q       <= cell_d;
      cap_cell_q   <= cap_cell_d;
      cap_valid_q  <= cap_valid_d;
      rom_addr_q   <= rom_addr_d;
      shadow_map_q <= shadow_map_d;
      shadow_vis_q <= shadow_vis_d;
      bad_q        <= bad_d;
      map_q        <= map_d;
      vis_q        <= vis_d;
      puzzle_id_q  <= puzzle_id_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_error_q <= load_error_d;
    end
  end

  assign rom_addr            = rom_addr_q;
  assign selected_map        = map_q;
  assign selected_visibility = vis_q;
  assign puzzle_id           = puzzle_id_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign load_error          = load_error_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// Bench for puzzle_loader: behavioural ROM, LFSR-based puzzle prediction and
// per-load expectations built directly from the ROM image.
module tb_puzzle_loader;
  localparam int unsigned NP    = 8;
  localparam int unsigned AW    = 10;
  localparam int          NCELL = 81;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          difficulty;
  logic [AW-1:0] rom_addr;
  logic [5:0]    rom_data;
  logic [323:0]  selected_map;
  logic [161:0]  selected_visibility;
  logic [3:0]    puzzle_id;
  logic          busy;
  logic          done;
  logic          load_error;

  always #5 clk = ~clk;

  puzzle_loader #(.NUM_PUZZLES(NP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .difficulty(difficulty),
    .rom_addr(rom_addr), .rom_data(rom_data), .selected_map(selected_map),
    .selected_visibility(selected_visibility), .puzzle_id(puzzle_id),
    .busy(busy), .done(done), .load_error(load_error)
  );

  logic [5:0] rom [0:NP*NCELL-1];
  always @(posedge clk)
    rom_data <= (int'(rom_addr) < NP * NCELL) ? rom[rom_addr] : 6'h00;

  // Reference random source: taps 7,5,4,3 as an XOR-reduction mask.
  logic [7:0] m_lfsr;
  always @(posedge clk)
    if (reset) m_lfsr <= 8'h01;
    else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};

  int vectors    = 0;
  int miscompares = 0;

  logic [323:0] last_map;
  logic [161:0] last_vis;
  logic [3:0]   last_id;

  task automatic check(input string name, input logic [323:0] got, input logic [323:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load_start = 1'b0;
    end
    check("hold_map", selected_map, last_map);
    check("hold_vis", {162'b0, selected_visibility}, {162'b0, last_vis});
    check("hold_id", puzzle_id, last_id);
  endtask

  // mode: 0 plain, 1 extra pulse mid-load, 2 pulse during commit cycle, 3 reset mid-load
  task automatic do_load(input bit diff, input int mode, input int exp_addr0,
                         input int exp_done_i, input int exp_err_i);
    int           idx, base, done_cnt, done_t;
    bit           model_bad, exp_done, exp_err, addr_ok, atomic_ok, busy_ok;
    logic [323:0] emap;
    logic [161:0] evis;
    idx       = int'(m_lfsr) % NP;
    base      = idx * NCELL;
    model_bad = 1'b0;
    for (int k = 0; k < NCELL; k++) begin
      emap[4*k +: 4] = rom[base+k][3:0];
      evis[2*k +: 2] = (diff ? rom[base+k][5] : rom[base+k][4]) ? 2'b11 : 2'b00;
      if (rom[base+k][3:0] == 4'd0 || rom[base+k][3:0] > 4'd9) model_bad = 1'b1;
    end
    exp_done  = (exp_done_i < 0) ? !model_bad : (exp_done_i != 0);
    exp_err   = (exp_err_i < 0) ? model_bad : (exp_err_i != 0);
    done_cnt  = 0;
    done_t    = 0;
    addr_ok   = 1'b1;
    atomic_ok = 1'b1;
    busy_ok   = 1'b1;
    load_start = 1'b1;
    difficulty = diff;
    for (int t = 1; t <= 85; t++) begin
      @(negedge clk);
      load_start = (mode == 1 && t == 40) || (mode == 2 && t == 83);
      difficulty = ~diff;
      if (done) begin done_cnt++; done_t = t; end
      if (mode == 3 && t == 51) begin
        check("rst_busy", busy, 0);
        check("rst_map", selected_map, 0);
        check("rst_vis", {162'b0, selected_visibility}, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_err", load_error, 0);
        check("rst_id", puzzle_id, 0);
        reset    = 1'b0;
        last_map = '0;
        last_vis = '0;
        last_id  = '0;
        break;
      end
      if (mode == 3 && t == 50) reset = 1'b1;
      if (t == 1) begin
        check("addr0", rom_addr, (exp_addr0 < 0) ? base : exp_addr0);
        check("err_clear", load_error, 0);
      end
      if (t <= 81 && int'(rom_addr) != base + t - 1) addr_ok = 1'b0;
      if (t > 81 && t <= 84 && int'(rom_addr) != base + 80) addr_ok = 1'b0;
      if (t <= 83) begin
        if (selected_map != 0 || selected_visibility != 0) atomic_ok = 1'b0;
        if (!busy) busy_ok = 1'b0;
      end
      if (t == 84) begin
        if (exp_done) begin
          last_map = emap;
          last_vis = evis;
          last_id  = idx[3:0];
        end else begin
          last_map = '0;
          last_vis = '0;
        end
        check("done", done, exp_done);
        check("map", selected_map, last_map);
        check("vis", {162'b0, selected_visibility}, {162'b0, last_vis});
        check("err", load_error, exp_err);
        check("busy_end", busy, 0);
        check("puzzle_id", puzzle_id, last_id);
        if (exp_done) begin
          check("vis_cell0", selected_visibility[1:0], diff ? 2'b00 : 2'b11);
          check("vis_cell80", selected_visibility[161:160], diff ? 2'b11 : 2'b00);
        end
      end
      if (t == 85) begin
        check("busy_idle", busy, 0);
        if (exp_done) check("done_time", done_t, 84);
      end
    end
    check("addr_seq", addr_ok, 1);
    check("atomic", atomic_ok, 1);
    check("busy_during", busy_ok, 1);
    check("done_count", done_cnt, (mode != 3 && exp_done) ? 1 : 0);
  endtask

  typedef struct {
    bit diff;
    int mode;
    bit corrupt;
    int exp_addr0;
    int exp_done;
    int exp_err;
  } vec_t;

  vec_t       tbl [6];
  logic [5:0] saved [NP];

  initial begin
    tbl[0] = '{diff: 1'b0, mode: 0, corrupt: 1'b0, exp_addr0: 81, exp_done: 1, exp_err: 0};
    tbl[1] = '{diff: 1'b1, mode: 1, corrupt: 1'b0, exp_addr0: -1, exp_done: 1, exp_err: 0};
    tbl[2] = '{diff: 1'b0, mode: 0, corrupt: 1'b1, exp_addr0: -1, exp_done: 0, exp_err: 1};
    tbl[3] = '{diff: 1'b1, mode: 2, corrupt: 1'b0, exp_addr0: -1, exp_done: 1, exp_err: 0};
    tbl[4] = '{diff: 1'b0, mode: 3, corrupt: 1'b0, exp_addr0: -1, exp_done: 0, exp_err: 0};
    tbl[5] = '{diff: 1'b1, mode: 0, corrupt: 1'b0, exp_addr0: 81, exp_done: 1, exp_err: 0};

    for (int a = 0; a < NP * NCELL; a++)
      rom[a] = {2'($urandom), 4'($urandom_range(1, 9))};
    for (int p = 0; p < NP; p++) begin
      rom[p*NCELL][5:4]      = 2'b01;
      rom[p*NCELL + 80][5:4] = 2'b10;
    end
    last_map = '0;
    last_vis = '0;
    last_id  = '0;

    reset      = 1'b1;
    load_start = 1'b0;
    difficulty = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_map", selected_map, 0);
    check("reset_vis", {162'b0, selected_visibility}, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", load_error, 0);
    check("reset_addr", rom_addr, 0);
    check("reset_id", puzzle_id, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].corrupt)
        for (int p = 0; p < NP; p++) begin
          saved[p] = rom[p*NCELL + 37];
          rom[p*NCELL + 37][3:0] = 4'hA;
        end
      do_load(tbl[i].diff, tbl[i].mode, tbl[i].exp_addr0, tbl[i].exp_done, tbl[i].exp_err);
      if (tbl[i].corrupt)
        for (int p = 0; p < NP; p++) rom[p*NCELL + 37] = saved[p];
      if (tbl[i].mode != 3) idle(3);
    end

    for (int r = 0; r < 10; r++) begin
      int         cp, cc, v;
      logic [5:0] keep;
      cp   = $urandom_range(0, NP - 1);
      cc   = $urandom_range(0, NCELL - 1);
      keep = rom[cp*NCELL + cc];
      if ($urandom_range(0, 2) == 0) begin
        v = $urandom_range(0, 6);
        rom[cp*NCELL + cc][3:0] = (v == 0) ? 4'd0 : 4'(9 + v);
      end
      idle($urandom_range(0, 15));
      do_load(1'($urandom), 0, -1, -1, -1);
      rom[cp*NCELL + cc] = keep;
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
